// File: rtl/life_pass_engine.sv
// Double-buffered cellular-automaton engine: streams the front bank through a 3-row window
// and writes each next-generation row into the back bank, flipping banks per generation.
module life_pass_engine #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 256,
  parameter int DBITS = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     gen_count,
  input  logic [8:0]                      birth_mask,
  input  logic [8:0]                      survive_mask,
  input  logic                            wrap_en,
  input  logic                            init_we,
  input  logic [DBITS-1:0]                init_addr,
  input  logic [WIDTH-1:0]                init_data,
  input  logic                            rd_en,
  input  logic [DBITS-1:0]                rd_addr,
  output logic [WIDTH-1:0]                rd_data,
  output logic                            rd_valid,
  output logic                            busy,
  output logic                            done,
  output logic [15:0]                     pass_cnt,
  output logic [DBITS+$clog2(WIDTH):0]    pop_count
);

  localparam int PW = DBITS + $clog2(WIDTH) + 1;
  localparam int CW = DBITS + 2;
  localparam logic [CW-1:0] RUN_LAST   = CW'(DEPTH + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DEPTH + 3);
  localparam logic [CW-1:0] FIRST_WR   = CW'(4);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic                 front;
  logic [15:0]          gen_q;
  logic [8:0]           birth_q, survive_q;
  logic                 wrap_q;
  logic [PW-1:0]        pop_acc;

  logic [WIDTH-1:0]     mem0 [DEPTH];
  logic [WIDTH-1:0]     mem1 [DEPTH];
  logic [WIDTH-1:0]     mem_q;
  logic                 rd_pend;

  logic [WIDTH-1:0]     win_top, win_mid, win_bot;
  logic [WIDTH-1:0]     top_row, bot_row, next_row;
  logic [WIDTH+1:0]     ext_t, ext_m, ext_b;

  logic                 idle, accept, last_drain, run_we, more, we0, we1;
  logic [DBITS-1:0]     run_raddr, raddr, waddr, wr_row;
  logic [WIDTH-1:0]     wdata;
  logic [PW-1:0]        row_pop;

  function automatic logic [3:0] count8(input logic [7:0] v);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 8; i++) s = s + 4'(v[i]);
    return s;
  endfunction

  function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + PW'(v[i]);
    return s;
  endfunction

  assign idle       = (state == IDLE);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign accept     = idle && start;
  assign last_drain = (state == DRAIN) && (cnt == DRAIN_LAST);
  assign more       = ({1'b0, pass_cnt} + 17'd1) < {1'b0, gen_q};

  // Row r is centred in the window on count r+4, so writes trail reads by four cycles.
  assign wr_row = DBITS'(cnt - FIRST_WR);
  assign run_we = busy && (cnt >= FIRST_WR);

  // Read sequence during a pass: last row, then 0..DEPTH-1, then row 0 again.
  always_comb begin
    if (cnt == CW'(0)) begin
      run_raddr = DBITS'(DEPTH - 1);
    end else if (cnt <= CW'(DEPTH)) begin
      run_raddr = DBITS'(cnt - CW'(1));
    end else begin
      run_raddr = '0;
    end
  end

  assign raddr = idle ? rd_addr   : run_raddr;
  assign waddr = idle ? init_addr : wr_row;
  assign wdata = idle ? init_data : next_row;
  assign we0   = (idle && init_we && !front) || (run_we && front);
  assign we1   = (idle && init_we && front)  || (run_we && !front);

  // Bank storage with registered read from the front bank.
  always_ff @(posedge clk) begin
    if (we0) mem0[waddr] <= wdata;
    if (we1) mem1[waddr] <= wdata;
    mem_q <= front ? mem1[raddr] : mem0[raddr];
  end

  // Three-row sliding window fed by the registered bank output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_top <= '0;
      win_mid <= '0;
      win_bot <= '0;
    end else if (busy) begin
      win_top <= win_mid;
      win_mid <= win_bot;
      win_bot <= mem_q;
    end
  end

  assign top_row = (!wrap_q && wr_row == DBITS'(0))         ? '0 : win_top;
  assign bot_row = (!wrap_q && wr_row == DBITS'(DEPTH - 1)) ? '0 : win_bot;
  assign ext_t = {wrap_q ? top_row[0] : 1'b0, top_row, wrap_q ? top_row[WIDTH-1] : 1'b0};
  assign ext_m = {wrap_q ? win_mid[0] : 1'b0, win_mid, wrap_q ? win_mid[WIDTH-1] : 1'b0};
  assign ext_b = {wrap_q ? bot_row[0] : 1'b0, bot_row, wrap_q ? bot_row[WIDTH-1] : 1'b0};

  // Rule lookup per column; ext_* index x+1 is column x.
  always_comb begin
    logic [3:0] n;
    n        = 4'd0;
    next_row = '0;
    for (int x = 0; x < WIDTH; x++) begin
      n = count8({ext_t[x +: 3], ext_b[x +: 3], ext_m[x], ext_m[x+2]});
      if (ext_m[x+1]) begin
        next_row[x] = survive_q[n];
      end else begin
        next_row[x] = birth_q[n];
      end
    end
  end

  assign row_pop = popcnt(next_row);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) state_nx = (gen_count == 16'd0) ? DONE : RUN;
        else       state_nx = IDLE;
      end
      RUN: begin
        if (cnt == RUN_LAST) state_nx = DRAIN;
        else                 state_nx = RUN;
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) state_nx = more ? RUN : DONE;
        else                   state_nx = DRAIN;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run configuration, pass counting, bank flip and population tally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      front     <= 1'b0;
      gen_q     <= 16'd0;
      birth_q   <= 9'd0;
      survive_q <= 9'd0;
      wrap_q    <= 1'b0;
      pass_cnt  <= 16'd0;
      pop_acc   <= '0;
      pop_count <= '0;
    end else if (accept) begin
      cnt       <= '0;
      gen_q     <= gen_count;
      birth_q   <= birth_mask;
      survive_q <= survive_mask;
      wrap_q    <= wrap_en;
      pass_cnt  <= 16'd0;
      pop_acc   <= '0;
    end else if (last_drain) begin
      cnt       <= '0;
      front     <= ~front;
      pass_cnt  <= pass_cnt + 16'd1;
      pop_count <= pop_acc + row_pop;
      pop_acc   <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (run_we) pop_acc <= pop_acc + row_pop;
    end
  end

  // Two-stage host read pipeline; only reads issued in IDLE are honoured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pend  <= idle && rd_en;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= mem_q;
    end
  end

endmodule

// File: tb/tb_life_pass_engine.sv
// Directed bench for life_pass_engine on a 16x16 image with hand-derived patterns.
module tb_life_pass_engine;

  logic        clk = 1'b0;
  logic        reset, start, wrap_en, init_we, rd_en;
  logic [15:0] gen_count, init_data, rd_data, pass_cnt;
  logic [8:0]  birth_mask, survive_mask, pop_count;
  logic [3:0]  init_addr, rd_addr;
  logic        rd_valid, busy, done;

  logic [15:0] img [16];
  logic [15:0] exp_img [16];
  logic [15:0] got [16];
  int tests, fails, done_at, busy_cyc, vmiss;

  life_pass_engine #(.WIDTH(16), .DEPTH(16), .DBITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .gen_count(gen_count),
    .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap_en(wrap_en),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .pop_count(pop_count)
  );

  always #5 clk = ~clk;

  task automatic clear_imgs();
    for (int r = 0; r < 16; r++) begin
      img[r] = 16'h0000;
      exp_img[r] = 16'h0000;
    end
  endtask

  task automatic load_image();
    for (int r = 0; r < 16; r++) begin
      init_we = 1'b1; init_addr = 4'(r); init_data = img[r];
      @(negedge clk);
    end
    init_we = 1'b0;
  endtask

  task automatic read_image();
    vmiss = 0;
    for (int j = 0; j < 18; j++) begin
      if (j >= 2) begin
        if (rd_valid !== 1'b1) vmiss++;
        got[j-2] = rd_data;
      end
      rd_en = (j < 16); rd_addr = 4'(j);
      @(negedge clk);
    end
    rd_en = 1'b0;
  endtask

  task automatic run_gens(input logic [15:0] g, input logic [8:0] b, input logic [8:0] s,
                          input logic w);
    gen_count = g; birth_mask = b; survive_mask = s; wrap_en = w; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_at = -1; busy_cyc = 0;
    for (int j = 0; j < 3000; j++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_at = j;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (rd_valid !== 1'b0)  begin fails++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    tests++; if (rd_data !== 16'h0)  begin fails++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    tests++; if (pass_cnt !== 16'd0) begin fails++; $display("FAIL reset_pass_cnt got %0d want 0", pass_cnt); end
    tests++; if (pop_count !== 9'd0) begin fails++; $display("FAIL reset_pop_count got %0d want 0", pop_count); end
  endtask

  task automatic test_init_read();
    init_we = 1'b1; init_addr = 4'd3; init_data = 16'hA5C3;
    @(negedge clk);
    init_we = 1'b0; rd_en = 1'b1; rd_addr = 4'd3;
    @(negedge clk);
    rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_latency1 got %b want 0", rd_valid); end
    @(negedge clk);
    tests++; if (rd_valid !== 1'b1 || rd_data !== 16'hA5C3)
      begin fails++; $display("FAIL rd_after_wr got %b/%h want 1/a5c3", rd_valid, rd_data); end
    @(negedge clk);
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL rd_single got %b want 0", rd_valid); end
    for (int r = 0; r < 16; r++) img[r] = 16'(r * 16'h0101) ^ 16'h5A00;
    load_image();
    read_image();
    tests++; if (vmiss !== 0) begin fails++; $display("FAIL b2b_valid got %0d misses want 0", vmiss); end
    for (int r = 0; r < 16; r++) begin
      tests++; if (got[r] !== img[r]) begin fails++; $display("FAIL b2b_row%0d got %h want %h", r, got[r], img[r]); end
    end
  endtask

  task automatic check_run(input string tag, input int want_done, input logic [15:0] want_pc,
                           input logic [8:0] want_pop);
    tests++; if (done_at !== want_done) begin fails++; $display("FAIL %s_done_at got %0d want %0d", tag, done_at, want_done); end
    tests++; if (busy_cyc !== want_done) begin fails++; $display("FAIL %s_busy got %0d want %0d", tag, busy_cyc, want_done); end
    tests++; if (pass_cnt !== want_pc) begin fails++; $display("FAIL %s_pass_cnt got %0d want %0d", tag, pass_cnt, want_pc); end
    tests++; if (pop_count !== want_pop) begin fails++; $display("FAIL %s_pop got %0d want %0d", tag, pop_count, want_pop); end
    read_image();
    for (int r = 0; r < 16; r++) begin
      tests++; if (got[r] !== exp_img[r]) begin fails++; $display("FAIL %s_row%0d got %h want %h", tag, r, got[r], exp_img[r]); end
    end
  endtask

  task automatic test_blinker();
    clear_imgs(); img[5] = 16'h0070;
    exp_img[4] = 16'h0020; exp_img[5] = 16'h0020; exp_img[6] = 16'h0020;
    load_image();
    run_gens(16'd1, 9'h008, 9'h00C, 1'b1);
    check_run("blinker", 20, 16'd1, 9'd3);
  endtask

  task automatic test_blinker_edge();
    clear_imgs(); img[0] = 16'h0070;
    exp_img[15] = 16'h0020; exp_img[0] = 16'h0020; exp_img[1] = 16'h0020;
    load_image();
    run_gens(16'd1, 9'h008, 9'h00C, 1'b1);
    check_run("edge_wrap", 20, 16'd1, 9'd3);
    exp_img[15] = 16'h0000;
    load_image();
    run_gens(16'd1, 9'h008, 9'h00C, 1'b0);
    check_run("edge_dead", 20, 16'd1, 9'd2);
  endtask

  task automatic test_glider();
    clear_imgs();
    img[1] = 16'h0004; img[2] = 16'h0008; img[3] = 16'h000E;
    for (int r = 0; r < 16; r++) exp_img[r] = img[r];
    load_image();
    run_gens(16'd64, 9'h008, 9'h00C, 1'b1);
    check_run("glider", 1280, 16'd64, 9'd5);
  endtask

  task automatic test_single_cell();
    clear_imgs(); img[8] = 16'h0100;
    exp_img[7] = 16'h0380; exp_img[8] = 16'h0280; exp_img[9] = 16'h0380;
    load_image();
    run_gens(16'd1, 9'h002, 9'h000, 1'b1);
    check_run("single", 20, 16'd1, 9'd8);
  endtask

  task automatic test_zero_gen();
    // Image and pop_count carry over from the single-cell run.
    run_gens(16'd0, 9'h008, 9'h00C, 1'b1);
    check_run("zero_gen", 0, 16'd0, 9'd8);
  endtask

  task automatic test_run_ignores();
    int vseen;
    clear_imgs(); img[5] = 16'h0070;
    exp_img[4] = 16'h0020; exp_img[5] = 16'h0020; exp_img[6] = 16'h0020;
    load_image();
    gen_count = 16'd1; birth_mask = 9'h008; survive_mask = 9'h00C; wrap_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; done_at = -1; busy_cyc = 0; vseen = 0;
    for (int j = 0; j < 3000; j++) begin
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        done_at = j;
        break;
      end
      if (rd_valid === 1'b1) vseen++;
      if (j == 5) begin
        start = 1'b1; gen_count = 16'd5; init_we = 1'b1; init_addr = 4'd5;
        init_data = 16'hFFFF; rd_en = 1'b1; rd_addr = 4'd5;
      end else begin
        start = 1'b0; init_we = 1'b0; rd_en = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; init_we = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    tests++; if (vseen !== 0) begin fails++; $display("FAIL busy_read got %0d valids want 0", vseen); end
    check_run("ignore", 20, 16'd1, 9'd3);
  endtask

  task automatic test_reset_mid_run();
    clear_imgs(); img[2] = 16'h0070;
    load_image();
    gen_count = 16'd3; birth_mask = 9'h008; survive_mask = 9'h00C; wrap_en = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrun_busy got %b want 1", busy); end
    reset = 1'b1;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (pass_cnt !== 16'd0 || pop_count !== 9'd0)
      begin fails++; $display("FAIL abort_counts got %0d/%0d want 0/0", pass_cnt, pop_count); end
    test_blinker();
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1; start = 1'b0; gen_count = 16'd0; birth_mask = 9'd0; survive_mask = 9'd0;
    wrap_en = 1'b0; init_we = 1'b0; init_addr = 4'd0; init_data = 16'd0; rd_en = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_init_read();
    test_blinker();
    test_blinker_edge();
    test_glider();
    test_single_cell();
    test_zero_gen();
    test_run_ignores();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
